sm4_rkey_scheduler: RTL and testbench

- Iterative SM4 key-expansion engine. It accepts a 128-bit cipher key, computes the 32 round keys at one per cycle, and stores them in an internal register file.
- It then streams the round keys to the round datapath: forward order (rk0..rk31) for encryption, reverse order (rk31..rk0) for decryption.
- It is the round-key producer that feeds the round datapath's per-round key input.

---
 rtl/sm4_rkey_scheduler.sv | 99 +++++++++
 tb/tb_sm4_rkey_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sm4_rkey_scheduler.sv
// sm4_rkey_scheduler: computes the 32 SM4 round keys one per cycle into a key file.
// It then streams them forward (encrypt) or in reverse (decrypt).
module sm4_rkey_scheduler #(
    parameter int word_width_p = 32,
    parameter int rounds_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    key_v_i,
    input  logic [127:0]            key_i,
    output logic                    key_ready_o,
    input  logic                    start_v_i,
    input  logic                    decrypt_i,
    output logic                    start_ready_o,
    output logic                    rkey_v_o,
    output logic [word_width_p-1:0] rkey_o,
    output logic [4:0]              rkey_idx_o,
    input  logic                    rkey_ready_i,
    output logic                    last_o
);
    typedef enum logic [1:0] {IDLE, EXPAND, LOADED, STREAM} state_e;
    localparam logic [127:0] fk = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    localparam logic [0:255][7:0] sbox_tbl = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic [7:0] m);
        return sbox_tbl[x ^ m];
    endfunction
    state_e state;
    logic [31:0] k0, k1, k2, k3, ck, x, b, rk;
    logic [4:0] cnt, nidx;
    logic dec;
    logic [word_width_p-1:0] rf [rounds_p];
    // CK bytes are (4c+j)*7 mod 256, generated from the counter instead of a table
    for (genvar j = 0; j < 4; j++) begin : g_byte
        assign ck[31-8*j -: 8] = {1'b0, cnt, 2'(j)} * 8'd7;
        assign b[31-8*j -: 8] = sbox(x[31-8*j -: 8], 8'h00);
    end
    assign x = k1 ^ k2 ^ k3 ^ ck;
    assign rk = k0 ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    assign key_ready_o = state == IDLE || (state == LOADED && !start_v_i);
    assign start_ready_o = state == LOADED;
    assign nidx = dec ? rkey_idx_o - 5'd1 : rkey_idx_o + 5'd1;
    always_ff @(posedge clk_i) begin
        if (state == EXPAND) rf[cnt] <= rk;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            rkey_v_o <= 1'b0;
            rkey_o <= '0;
            rkey_idx_o <= '0;
            last_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (key_v_i) begin
                    {k0, k1, k2, k3} <= key_i ^ fk;
                    cnt <= '0;
                    state <= EXPAND;
                end
                EXPAND: begin
                    {k0, k1, k2, k3} <= {k1, k2, k3, rk};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= LOADED;
                end
                LOADED: if (start_v_i) begin
                    dec <= decrypt_i;
                    rkey_v_o <= 1'b1;
                    rkey_idx_o <= decrypt_i ? 5'd31 : 5'd0;
                    rkey_o <= rf[decrypt_i ? 5'd31 : 5'd0];
                    last_o <= 1'b0;
                    state <= STREAM;
                end else if (key_v_i) begin
                    {k0, k1, k2, k3} <= key_i ^ fk;
                    cnt <= '0;
                    state <= EXPAND;
                end
                STREAM: if (rkey_ready_i) begin
                    if (last_o) begin
                        rkey_v_o <= 1'b0;
                        last_o <= 1'b0;
                        state <= LOADED;
                    end else begin
                        rkey_idx_o <= nidx;
                        rkey_o <= rf[nidx];
                        last_o <= nidx == (dec ? 5'd0 : 5'd31);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm4_rkey_scheduler.sv
// tb_sm4_rkey_scheduler: directed checks of expansion latency, forward/reverse streaming,
// backpressure, mid-operation reset and key/start collision.
module tb_sm4_rkey_scheduler;
    logic clk = 0, reset = 1, key_v = 0, start_v = 0, decrypt = 0, rkey_ready = 0;
    logic [127:0] key = '0;
    logic key_ready, start_ready, rkey_v, last;
    logic [31:0] rkey;
    logic [4:0] idx;
    int tests = 0, fails = 0;
    logic [31:0] ref_keys [32];
    localparam logic [127:0] mk = 128'h0123456789abcdeffedcba9876543210;
    typedef struct {
        logic dec;
        logic bp;
        logic capture;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;
    sm4_rkey_scheduler dut (
        .clk_i(clk), .reset_i(reset), .key_v_i(key_v), .key_i(key), .key_ready_o(key_ready),
        .start_v_i(start_v), .decrypt_i(decrypt), .start_ready_o(start_ready),
        .rkey_v_o(rkey_v), .rkey_o(rkey), .rkey_idx_o(idx), .rkey_ready_i(rkey_ready), .last_o(last)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic load_key(input logic [127:0] k, input string name);
        int n;
        n = 0;
        chk({name, " key_ready before load"}, 32'(key_ready), 32'd1);
        key = k;
        key_v = 1;
        tick;
        key_v = 0;
        chk({name, " key_ready while expanding"}, 32'(key_ready), 32'd0);
        while (!start_ready && n < 100) begin
            tick;
            n++;
        end
        chk({name, " start latency"}, 32'(n + 1), 32'd33);
    endtask
    task automatic run_stream(input logic dec, input logic bp, input logic capture, input logic check_val,
                              input logic with_key, input logic [31:0] first_k, input logic [31:0] last_k,
                              input string name);
        int stalls, e;
        logic [31:0] hold_k;
        logic [4:0] hold_i;
        logic hold_l;
        chk({name, " start_ready"}, 32'(start_ready), 32'd1);
        start_v = 1;
        decrypt = dec;
        rkey_ready = 0;
        if (with_key) begin
            key_v = 1;
            key = '0;
            #1;
            chk({name, " key_ready in collision"}, 32'(key_ready), 32'd0);
        end
        tick;
        start_v = 0;
        key_v = 0;
        for (int n = 0; n < 32; n++) begin
            e = dec ? 31 - n : n;
            chk({name, " valid"}, 32'(rkey_v), 32'd1);
            chk({name, " idx"}, 32'(idx), 32'(e));
            chk({name, " last"}, 32'(last), 32'(n == 31));
            if (check_val && n == 0) chk({name, " first key"}, rkey, first_k);
            if (check_val && n == 31) chk({name, " last key"}, rkey, last_k);
            if (capture) ref_keys[e] = rkey;
            else if (check_val) chk({name, " key vs first stream"}, rkey, ref_keys[e]);
            stalls = 0;
            hold_k = rkey;
            hold_i = idx;
            hold_l = last;
            rkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!rkey_ready) begin
                tick;
                chk({name, " stall key stable"}, rkey, hold_k);
                chk({name, " stall ctrl stable"}, 32'({rkey_v, last, idx}), 32'({1'b1, hold_l, hold_i}));
                stalls++;
                rkey_ready = stalls >= 4 ? 1'b1 : 1'($urandom_range(0, 1));
            end
            tick;
        end
        rkey_ready = 0;
        chk({name, " valid low after stream"}, 32'(rkey_v), 32'd0);
        chk({name, " start_ready after stream"}, 32'(start_ready), 32'd1);
    endtask
    task automatic check_after_reset(input string name);
        chk({name, " rkey_v"}, 32'(rkey_v), 32'd0);
        chk({name, " key_ready"}, 32'(key_ready), 32'd1);
        chk({name, " start_ready"}, 32'(start_ready), 32'd0);
        chk({name, " last"}, 32'(last), 32'd0);
        start_v = 1;
        repeat (3) tick;
        start_v = 0;
        chk({name, " start ignored rkey_v"}, 32'(rkey_v), 32'd0);
        chk({name, " start ignored start_ready"}, 32'(start_ready), 32'd0);
    endtask
    initial begin
        vec_t vecs [5];
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'hf12186f9, 32'h9124a012};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h9124a012, 32'hf12186f9};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'hf12186f9, 32'h9124a012};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'hf12186f9, 32'h9124a012};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h9124a012, 32'hf12186f9};
        reset = 1;
        tick;
        tick;
        reset = 0;
        chk("reset rkey_o", rkey, 32'd0);
        chk("reset rkey_idx_o", 32'(idx), 32'd0);
        check_after_reset("reset");
        load_key(mk, "fwd key");
        for (int i = 0; i < 5; i++)
            run_stream(vecs[i].dec, vecs[i].bp, vecs[i].capture, 1'b1, 1'b0,
                       vecs[i].first, vecs[i].last, $sformatf("vec%0d", i));
        key = mk;
        key_v = 1;
        tick;
        key_v = 0;
        repeat (10) tick;
        reset = 1;
        tick;
        reset = 0;
        check_after_reset("reset mid-expand");
        load_key(mk, "reload after expand reset");
        run_stream(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hf12186f9, 32'h9124a012, "after expand reset");
        start_v = 1;
        decrypt = 0;
        rkey_ready = 1;
        tick;
        start_v = 0;
        repeat (5) tick;
        reset = 1;
        tick;
        reset = 0;
        rkey_ready = 0;
        check_after_reset("reset mid-stream");
        load_key(mk, "reload after stream reset");
        run_stream(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hf12186f9, 32'h9124a012, "collision");
        load_key('0, "zero key");
        run_stream(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "zero key reverse");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
